// File: rtl/bcd_display_sequencer_pkg.sv
// Shared constants, state encoding and parameter legality check for the BCD display sequencer.
package bcd_display_sequencer_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hE;
    localparam logic [3:0] HALT_CODE  = 4'hF;

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StPublish,
        StHalted
    } state_e;

    // True when NDIG decimal digits can hold the largest WIDTH-bit unsigned value.
    function automatic bit digits_fit(input int unsigned width, input int unsigned ndig);
        longint unsigned pow10;
        longint unsigned maxval;
        pow10 = 64'd1;
        for (int unsigned i = 0; i < ndig; i++) begin
            pow10 = pow10 * 64'd10;
        end
        maxval = (64'd1 << width) - 64'd1;
        return pow10 > maxval;
    endfunction

endpackage

// File: rtl/bcd_display_sequencer_add3_row.sv
// Combinational add-3 correction applied to every BCD nibble before each shift.
module bcd_add3_row #(
    parameter int unsigned NDIG = 5
) (
    input  logic [4*NDIG-1:0] i_bcd,
    output logic [4*NDIG-1:0] o_bcd
);

    always_comb begin
        o_bcd = i_bcd;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (i_bcd[4*i +: 4] >= 4'd5) begin
                o_bcd[4*i +: 4] = i_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

endmodule

// File: rtl/bcd_display_sequencer.sv
// Iterative binary-to-BCD converter driving 7-segment digit decoders, with
// leading-zero blanking, halt override and a single pending-update slot.
module bcd_display_sequencer
    import bcd_display_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NDIG  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WIDTH-1:0]  value,
    input  logic              load,
    input  logic              halt,
    output logic [4*NDIG-1:0] digits,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    if (!digits_fit(WIDTH, NDIG)) begin : g_ndig_check
        $error("NDIG too small to represent every WIDTH-bit value");
    end

    state_e            r_state,      w_state_d;
    logic [WIDTH-1:0]  r_shift,      w_shift_d;
    logic [4*NDIG-1:0] r_bcd,        w_bcd_d;
    logic [CW-1:0]     r_cnt,        w_cnt_d;
    logic              r_pend,       w_pend_d;
    logic [WIDTH-1:0]  r_pend_val,   w_pend_val_d;
    logic [4*NDIG-1:0] r_digits,     w_digits_d;
    logic [4*NDIG-1:0] r_shadow,     w_shadow_d;
    logic              r_busy,       w_busy_d;
    logic              r_done,       w_done_d;

    logic [4*NDIG-1:0] w_adj;
    logic [4*NDIG-1:0] w_blanked;
    logic              w_seen;
    logic              w_start;
    logic [WIDTH-1:0]  w_start_val;

    bcd_add3_row #(
        .NDIG (NDIG)
    ) u_add3_row (
        .i_bcd (r_bcd),
        .o_bcd (w_adj)
    );

    // Blank every digit above the most significant nonzero one; digit 0 always shows.
    always_comb begin
        w_seen    = 1'b0;
        w_blanked = r_bcd;
        for (int i = int'(NDIG) - 1; i >= 1; i--) begin
            if (r_bcd[4*i +: 4] != 4'd0) begin
                w_seen = 1'b1;
            end
            if (!w_seen) begin
                w_blanked[4*i +: 4] = BLANK_CODE;
            end
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_shift_d    = r_shift;
        w_bcd_d      = r_bcd;
        w_cnt_d      = r_cnt;
        w_pend_d     = r_pend;
        w_pend_val_d = r_pend_val;
        w_digits_d   = r_digits;
        w_shadow_d   = r_shadow;
        w_done_d     = 1'b0;
        w_start      = 1'b0;
        w_start_val  = value;

        if (halt) begin
            w_state_d  = StHalted;
            w_digits_d = {NDIG{HALT_CODE}};
            if (load) begin
                w_pend_d     = 1'b1;
                w_pend_val_d = value;
            end
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (load) begin
                        w_start = 1'b1;
                    end else if (r_pend) begin
                        w_start     = 1'b1;
                        w_start_val = r_pend_val;
                    end
                end
                StConvert: begin
                    w_bcd_d   = {w_adj[4*NDIG-2:0], r_shift[WIDTH-1]};
                    w_shift_d = {r_shift[WIDTH-2:0], 1'b0};
                    w_cnt_d   = r_cnt + CW'(1);
                    if (r_cnt == CNT_LAST) begin
                        w_state_d = StPublish;
                    end
                    if (load) begin
                        w_pend_d     = 1'b1;
                        w_pend_val_d = value;
                    end
                end
                StPublish: begin
                    w_digits_d = w_blanked;
                    w_shadow_d = w_blanked;
                    w_done_d   = 1'b1;
                    w_state_d  = StIdle;
                    // A load landing on the publish cycle beats any older pending value.
                    if (load) begin
                        w_start = 1'b1;
                    end else if (r_pend) begin
                        w_start     = 1'b1;
                        w_start_val = r_pend_val;
                    end
                end
                StHalted: begin
                    w_digits_d = r_shadow;
                    w_state_d  = StIdle;
                    if (load) begin
                        w_pend_d     = 1'b1;
                        w_pend_val_d = value;
                    end
                end
                default: begin
                    w_state_d = StIdle;
                end
            endcase
        end

        if (w_start) begin
            w_state_d = StConvert;
            w_shift_d = w_start_val;
            w_bcd_d   = '0;
            w_cnt_d   = '0;
            w_pend_d  = 1'b0;
        end

        // busy also covers the cycle in which done is presented.
        w_busy_d = (w_state_d == StConvert) || (w_state_d == StPublish) ||
                   ((r_state == StPublish) && (w_state_d == StIdle));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= StIdle;
            r_shift    <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_pend     <= 1'b0;
            r_pend_val <= '0;
            r_digits   <= {NDIG{BLANK_CODE}};
            r_shadow   <= {NDIG{BLANK_CODE}};
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_shift    <= w_shift_d;
            r_bcd      <= w_bcd_d;
            r_cnt      <= w_cnt_d;
            r_pend     <= w_pend_d;
            r_pend_val <= w_pend_val_d;
            r_digits   <= w_digits_d;
            r_shadow   <= w_shadow_d;
            r_busy     <= w_busy_d;
            r_done     <= w_done_d;
        end
    end

    assign digits = r_digits;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_bcd_display_sequencer.sv
// Self-checking bench: directed scenarios plus random loads against a decimal reference model.
module tb_bcd_display_sequencer;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NDIG  = 5;

    logic              clock = 1'b0;
    logic              reset;
    logic [WIDTH-1:0]  value;
    logic              load;
    logic              halt;
    logic [4*NDIG-1:0] digits;
    logic              busy;
    logic              done;

    int                n_cmp  = 0;
    int                n_fail = 0;
    logic [4*NDIG-1:0] last_disp;

    always #5 clock = ~clock;

    bcd_display_sequencer #(
        .WIDTH (WIDTH),
        .NDIG  (NDIG)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .value  (value),
        .load   (load),
        .halt   (halt),
        .digits (digits),
        .busy   (busy),
        .done   (done)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decimal digits by division, then blank everything above the top nonzero digit.
    function automatic logic [4*NDIG-1:0] ref_digits(input int unsigned v);
        int unsigned       n;
        int                top;
        logic [3:0]        d [NDIG];
        logic [4*NDIG-1:0] r;
        n   = v;
        top = 0;
        for (int i = 0; i < int'(NDIG); i++) begin
            d[i] = 4'(n % 10);
            n    = n / 10;
            if (d[i] != 4'd0) top = i;
        end
        for (int i = 0; i < int'(NDIG); i++) begin
            r[4*i +: 4] = (i > top) ? 4'hE : d[i];
        end
        return r;
    endfunction

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            tick();
            if (done === 1'b1) cnt++;
        end
    endtask

    task automatic run_one(input int unsigned v, input string tag);
        int lat;
        value = WIDTH'(v);
        load  = 1'b1;
        tick();
        load  = 1'b0;
        check({tag, ".busy_start"}, 64'(busy), 64'd1);
        wait_done(40, lat);
        check({tag, ".latency"}, 64'(lat), 64'(WIDTH + 1));
        check({tag, ".digits"}, 64'(digits), 64'(ref_digits(v)));
        check({tag, ".busy_at_done"}, 64'(busy), 64'd1);
        last_disp = ref_digits(v);
        tick();
        check({tag, ".busy_end"}, 64'(busy), 64'd0);
        check({tag, ".done_end"}, 64'(done), 64'd0);
    endtask

    // Load a, then b at offset dm and c at offset d (edges after a's load); c must win.
    task automatic run_pending(input int unsigned a, input int unsigned b, input int unsigned c,
                               input int dm, input int d, input string tag);
        int early;
        int lat;
        int extra;
        value = WIDTH'(a);
        load  = 1'b1;
        tick();
        early = 0;
        for (int t = 1; t <= int'(WIDTH) + 1; t++) begin
            if (t == dm) begin
                value = WIDTH'(b);
                load  = 1'b1;
            end else if (t == d) begin
                value = WIDTH'(c);
                load  = 1'b1;
            end else begin
                load = 1'b0;
            end
            tick();
            if (t < int'(WIDTH) + 1 && done === 1'b1) early++;
        end
        load = 1'b0;
        check({tag, ".no_early_done"}, 64'(early), 64'd0);
        check({tag, ".first_done"}, 64'(done), 64'd1);
        check({tag, ".first_digits"}, 64'(digits), 64'(ref_digits(a)));
        tick();
        check({tag, ".busy_between"}, 64'(busy), 64'd1);
        wait_done(40, lat);
        check({tag, ".second_latency"}, 64'(lat), 64'(WIDTH));
        check({tag, ".second_digits"}, 64'(digits), 64'(ref_digits(c)));
        last_disp = ref_digits(c);
        count_dones(30, extra);
        check({tag, ".no_third_done"}, 64'(extra), 64'd0);
        check({tag, ".idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int lat;
        int cnt;
        int unsigned ra;
        int unsigned rb;
        int unsigned rc;
        int dm;
        int dd;

        reset = 1'b1;
        load  = 1'b0;
        halt  = 1'b0;
        value = '0;
        repeat (3) tick();
        check("reset.digits", 64'(digits), 64'hEEEEE);
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        reset = 1'b0;
        tick();
        check("post_reset.digits", 64'(digits), 64'hEEEEE);
        last_disp = 20'hEEEEE;

        // Shadow starts blank: a halt right after reset restores blanks.
        halt = 1'b1;
        tick();
        check("halt0.digits", 64'(digits), 64'hFFFFF);
        halt = 1'b0;
        tick();
        check("halt0.restore", 64'(digits), 64'hEEEEE);

        run_one(1234, "v1234");
        check("v1234.const", 64'(last_disp), 64'hE1234);
        run_one(0, "v0");
        check("v0.const", 64'(digits), 64'hEEEE0);
        run_one(65535, "v65535");
        check("v65535.const", 64'(digits), 64'h65535);

        run_pending(42, 7, 9, 3, 6, "pend");
        check("pend.const", 64'(last_disp), 64'hEEEE9);
        run_pending(315, 8, 2718, 5, int'(WIDTH) + 1, "pend_publish");

        // Halt mid-conversion aborts without done and restores the previous display.
        value = WIDTH'(500);
        load  = 1'b1;
        tick();
        load  = 1'b0;
        repeat (4) tick();
        halt = 1'b1;
        tick();
        check("halt.digits", 64'(digits), 64'hFFFFF);
        check("halt.busy", 64'(busy), 64'd0);
        check("halt.done", 64'(done), 64'd0);
        count_dones(5, cnt);
        check("halt.held_no_done", 64'(cnt), 64'd0);
        halt = 1'b0;
        tick();
        check("halt.restore", 64'(digits), 64'(last_disp));
        check("halt.restore_busy", 64'(busy), 64'd0);
        count_dones(30, cnt);
        check("halt.aborted_no_done", 64'(cnt), 64'd0);

        // Load during halt is queued and started one cycle after halt drops.
        halt  = 1'b1;
        tick();
        value = WIDTH'(321);
        load  = 1'b1;
        tick();
        load  = 1'b0;
        tick();
        check("halt_pend.digits", 64'(digits), 64'hFFFFF);
        halt = 1'b0;
        tick();
        check("halt_pend.restore", 64'(digits), 64'(last_disp));
        check("halt_pend.busy_restore", 64'(busy), 64'd0);
        wait_done(40, lat);
        check("halt_pend.latency", 64'(lat), 64'(WIDTH + 2));
        check("halt_pend.digits_new", 64'(digits), 64'(ref_digits(321)));
        last_disp = ref_digits(321);

        // Halt on the publish cycle suppresses done and the shadow update.
        value = WIDTH'(8080);
        load  = 1'b1;
        tick();
        load  = 1'b0;
        repeat (WIDTH) tick();
        halt = 1'b1;
        tick();
        check("halt_pub.done", 64'(done), 64'd0);
        check("halt_pub.digits", 64'(digits), 64'hFFFFF);
        halt = 1'b0;
        tick();
        check("halt_pub.restore", 64'(digits), 64'(last_disp));

        // Reset mid-conversion.
        value = WIDTH'(777);
        load  = 1'b1;
        tick();
        load  = 1'b0;
        repeat (8) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid.digits", 64'(digits), 64'hEEEEE);
        check("rst_mid.busy", 64'(busy), 64'd0);
        check("rst_mid.done", 64'(done), 64'd0);
        count_dones(30, cnt);
        check("rst_mid.no_done", 64'(cnt), 64'd0);
        last_disp = 20'hEEEEE;
        run_one(99, "v99");
        check("v99.const", 64'(digits), 64'hEEE99);

        for (int i = 0; i < 20; i++) begin
            run_one($urandom_range(65535, 0), "rand");
        end
        for (int i = 0; i < 5; i++) begin
            ra = $urandom_range(65535, 0);
            rb = $urandom_range(65535, 0);
            rc = $urandom_range(999, 0);
            dm = int'($urandom_range(WIDTH, 1));
            dd = int'($urandom_range(WIDTH + 1, dm + 1));
            run_pending(ra, rb, rc, dm, dd, "rand_pend");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
